lutram_fifo: RTL and testbench
==============================

Name: lutram_fifo

Overview:
- Parametrised synchronous FIFO built on distributed (LUT) RAM with asynchronous read, for first-word-fall-through (FWFT) output.
- Generalises the 128x1 dual-port select RAM to WIDTH x 2^DEPTH_LOG2 storage, and adds pointer, flag, level and error bookkeeping.
- Used as a small rate-decoupling buffer between same-clock pipelines in Verilator-simulated Xilinx designs.

Parameters:
- WIDTH, 8: data width in bits, 1..64.
- DEPTH_LOG2, 7: log2 of RAM entries (DEPTH = 2^DEPTH_LOG2 = 128), 2..10.

Ports:
- CLK  in  1  single clock; all state changes on its rising edge.
- RST_N  in  1  synchronous active-low reset, sampled on the rising edge of CLK.
- WR_EN  in  1  push request.
- WR_DATA  in  WIDTH  push data.
- RD_EN  in  1  pop request; acknowledges the head word currently on RD_DATA.
- RD_DATA  out  WIDTH  head word (FWFT); valid only while EMPTY=0.
- FULL  out  1  no push accepted this cycle.
- EMPTY  out  1  no word available.
- LEVEL  out  DEPTH_LOG2+1  words held.
- OVF  out  1  sticky: a push was attempted while FULL=1.
- UDF  out  1  sticky: a pop was attempted while EMPTY=1.

Behaviour:
- Reset, when RST_N=0 at an edge:
  - Pointers, LEVEL, OVF and UDF are cleared; EMPTY=1; FULL=0.
  - RAM contents are not cleared. Power-up RAM content is all-zero.
  - Reset mid-operation discards all stored words. Requests in the reset cycle are ignored.
- Storage: RAM of DEPTH x WIDTH. Synchronous write at wr_ptr; asynchronous read at rd_ptr.
- Pointers are DEPTH_LOG2+1 bits and wrap naturally modulo 2*DEPTH.
  - EMPTY = (wr_ptr == rd_ptr).
  - FULL = MSBs differ and the low bits are equal.
  - LEVEL = wr_ptr - rd_ptr, modulo 2^(DEPTH_LOG2+1).
- Push accepted iff WR_EN=1 and FULL=0 (pre-edge value). The RAM is written and wr_ptr increments.
- Pop accepted iff RD_EN=1 and EMPTY=0 (pre-edge value). rd_ptr increments.
- All flags and LEVEL are registered-state derived. They update the cycle after the edge that accepted the operation.
- Latency: a word pushed at edge N is visible on RD_DATA with EMPTY=0 after edge N (zero bubble, FWFT).
- Simultaneous push and pop:
  - Neither FULL nor EMPTY: both are accepted and LEVEL is unchanged.
  - FULL: the pop is accepted, the push is rejected and OVF is set.
  - EMPTY: the push is accepted, the pop is rejected and UDF is set.
- Rejected operations never modify pointers or RAM. OVF and UDF clear only on reset.
- RD_DATA while EMPTY=1 shows RAM[rd_ptr] (stale). The bench must not check it.

Optional Feature:
- Macro: LUTRAM_FIFO_OREG_EN.
- Defined: adds a WIDTH-bit output register and valid bit after the RAM.
  - RD_DATA is driven from flops, giving better timing.
  - Capacity becomes DEPTH+1; FULL asserts when LEVEL = DEPTH+1; LEVEL counts the output register.
  - The output register loads from the RAM head whenever it is empty or being popped and the RAM is non-empty.
  - When the RAM is empty, a push bypasses directly into the output register. Write-to-visible latency therefore stays at 1 edge.
  - EMPTY = !valid.
- Not defined: pure asynchronous-read FWFT as described above, with capacity DEPTH.

Decomposition:
- Package lutram_fifo_pkg holds:
  - the pointer-width function clog2-style helper,
  - LEVEL width constant expressions,
  - the capacity function (DEPTH or DEPTH+1, depending on the macro).
- Natural sub-module lutram_sdp: parametrised WIDTH x DEPTH simple dual-port distributed RAM with synchronous write and asynchronous read, initialised to zero. It is the direct generalisation of the 1-bit select RAM.

Test Plan:
- Reset then idle: after RST_N=0 for 2 edges -> EMPTY=1, FULL=0, LEVEL=0, OVF=0, UDF=0.
- Single word: push 0xA5 -> next cycle EMPTY=0, RD_DATA=0xA5, LEVEL=1; pop -> EMPTY=1, LEVEL=0.
- Fill and overflow, DEPTH=128, OREG off:
  - Push 0x00..0x7F -> FULL=1, LEVEL=128.
  - Extra push of 0xFF -> OVF=1, LEVEL=128.
  - Drain -> data 0x00..0x7F in order.
- Underflow and simultaneous on empty: RD_EN=1 with EMPTY=1 plus push 0x3C in the same cycle -> UDF=1, LEVEL=1, RD_DATA=0x3C.
- Wrap-around streaming: 300 cycles of push and pop every cycle after preloading 5 words -> LEVEL stays 5, output sequence matches input, pointers wrap past 256.
- Reset mid-operation: with LEVEL=40, assert RST_N=0 for one edge while WR_EN=1 -> LEVEL=0, EMPTY=1. The next push of 0x11 is read back first.
  - With LUTRAM_FIFO_OREG_EN defined, repeat the fill test: FULL asserts at LEVEL=129.

Source files
------------

// File: rtl/lutram_fifo_pkg.sv
// Shared sizing helpers for the LUT-RAM FIFO.
// The capacity depends on LUTRAM_FIFO_OREG_EN: DEPTH words without it, DEPTH+1 with the output register.
package lutram_fifo_pkg;

  function automatic int clog2_fn(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  function automatic int ptr_width(input int depth_log2);
    return depth_log2 + 1;
  endfunction

  function automatic int level_width(input int depth_log2);
    return clog2_fn((1 << depth_log2) * 2);
  endfunction

  function automatic int fifo_capacity(input int depth_log2);
`ifdef LUTRAM_FIFO_OREG_EN
    return (1 << depth_log2) + 1;
`else
    return (1 << depth_log2);
`endif
  endfunction

endpackage

// File: rtl/lutram_sdp.sv
// Simple dual-port distributed RAM: synchronous write, asynchronous read.
// The array is not reset; as LUT RAM its power-up content is all zero.
module lutram_sdp #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 7
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_waddr,
  input  logic [WIDTH-1:0]      i_wdata,
  input  logic [DEPTH_LOG2-1:0] i_raddr,
  output logic [WIDTH-1:0]      o_rdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/lutram_fifo.sv
// First-word-fall-through FIFO on distributed RAM with sticky overflow/underflow flags.
// Define LUTRAM_FIFO_OREG_EN to register RD_DATA (adds one word of capacity).
module lutram_fifo
  import lutram_fifo_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 7
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  WR_EN,
  input  logic [WIDTH-1:0]      WR_DATA,
  input  logic                  RD_EN,
  output logic [WIDTH-1:0]      RD_DATA,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic [DEPTH_LOG2:0]   LEVEL,
  output logic                  OVF,
  output logic                  UDF
);

  localparam int PW  = ptr_width(DEPTH_LOG2);
  localparam int LW  = level_width(DEPTH_LOG2);
  localparam int CAP = fifo_capacity(DEPTH_LOG2);

  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic             r_ovf;
  logic             r_udf;

  logic             w_ram_empty;
  logic [PW-1:0]    w_ram_level;
  logic [WIDTH-1:0] w_ram_rdata;
  logic             w_ram_we;
  logic             w_rd_adv;
  logic             w_full;
  logic             w_empty;
  logic             w_push_ok;
  logic             w_pop_ok;
  logic [LW-1:0]    w_level;

  assign w_ram_empty = (r_wr_ptr == r_rd_ptr);
  assign w_ram_level = r_wr_ptr - r_rd_ptr;

  lutram_sdp #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk     (CLK),
    .i_we    (w_ram_we),
    .i_waddr (r_wr_ptr[DEPTH_LOG2-1:0]),
    .i_wdata (WR_DATA),
    .i_raddr (r_rd_ptr[DEPTH_LOG2-1:0]),
    .o_rdata (w_ram_rdata)
  );

`ifdef LUTRAM_FIFO_OREG_EN
  logic             r_oreg_vld;
  logic [WIDTH-1:0] r_oreg_data;
  logic             w_oreg_take;
  logic             w_bypass;

  // The output register refills whenever it is empty or its word leaves this cycle.
  assign w_oreg_take = !r_oreg_vld || w_pop_ok;
  assign w_level     = LW'(w_ram_level) + LW'(r_oreg_vld);
  assign w_full      = (w_level == LW'(CAP));
  assign w_empty     = !r_oreg_vld;
  assign w_push_ok   = WR_EN && !w_full;
  assign w_pop_ok    = RD_EN && r_oreg_vld;
  assign w_bypass    = w_push_ok && w_oreg_take && w_ram_empty;
  assign w_ram_we    = RST_N && w_push_ok && !w_bypass;
  assign w_rd_adv    = w_oreg_take && !w_ram_empty;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_oreg_vld <= 1'b0;
    end else if (w_oreg_take) begin
      r_oreg_vld <= !w_ram_empty || w_push_ok;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST_N && w_oreg_take) begin
      if (!w_ram_empty)   r_oreg_data <= w_ram_rdata;
      else if (w_push_ok) r_oreg_data <= WR_DATA;
    end
  end

  assign RD_DATA = r_oreg_data;
`else
  logic w_ram_full;

  assign w_ram_full = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                      (r_wr_ptr[PW-2:0] == r_rd_ptr[PW-2:0]);
  assign w_level    = LW'(w_ram_level);
  assign w_full     = w_ram_full;
  assign w_empty    = w_ram_empty;
  assign w_push_ok  = WR_EN && !w_full;
  assign w_pop_ok   = RD_EN && !w_empty;
  assign w_ram_we   = RST_N && w_push_ok;
  assign w_rd_adv   = w_pop_ok;
  assign RD_DATA    = w_ram_rdata;
`endif

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      if (w_ram_we)          r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_adv)          r_rd_ptr <= r_rd_ptr + 1'b1;
      if (WR_EN && w_full)   r_ovf    <= 1'b1;
      if (RD_EN && w_empty)  r_udf    <= 1'b1;
    end
  end

  assign FULL  = w_full;
  assign EMPTY = w_empty;
  assign LEVEL = w_level;
  assign OVF   = r_ovf;
  assign UDF   = r_udf;

endmodule

// File: tb/tb_lutram_fifo.sv
// Self-checking bench for lutram_fifo: queue-based reference plus directed literal checks.
module tb_lutram_fifo;

`ifdef LUTRAM_FIFO_OREG_EN
  localparam int CAP = 129;
`else
  localparam int CAP = 128;
`endif

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       WR_EN = 1'b0;
  logic       RD_EN = 1'b0;
  logic [7:0] WR_DATA = 8'h00;
  logic [7:0] RD_DATA;
  logic       FULL, EMPTY, OVF, UDF;
  logic [7:0] LEVEL;

  int n_cmp = 0;
  int n_bad = 0;

  lutram_fifo #(.WIDTH(8), .DEPTH_LOG2(7)) dut (
    .CLK(CLK), .RST_N(RST_N), .WR_EN(WR_EN), .WR_DATA(WR_DATA), .RD_EN(RD_EN),
    .RD_DATA(RD_DATA), .FULL(FULL), .EMPTY(EMPTY), .LEVEL(LEVEL), .OVF(OVF), .UDF(UDF)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a queue of held words with capacity CAP, sticky error bits.
  logic [7:0] mq[$];
  bit m_ovf, m_udf, m_live;
  bit m_full, m_empty;

  always @(posedge CLK) begin
    if (!RST_N) begin
      mq.delete();
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
      m_live = 1'b1;
    end else begin
      m_full  = (mq.size() == CAP);
      m_empty = (mq.size() == 0);
      if (WR_EN && m_full)  m_ovf = 1'b1;
      if (RD_EN && m_empty) m_udf = 1'b1;
      if (RD_EN && !m_empty) void'(mq.pop_front());
      if (WR_EN && !m_full)  mq.push_back(WR_DATA);
    end
  end

  always @(negedge CLK) begin
    if (m_live) begin
      chk("EMPTY", 32'(EMPTY), 32'(mq.size() == 0));
      chk("FULL",  32'(FULL),  32'(mq.size() == CAP));
      chk("LEVEL", 32'(LEVEL), 32'(mq.size()));
      chk("OVF",   32'(OVF),   32'(m_ovf));
      chk("UDF",   32'(UDF),   32'(m_udf));
      if (mq.size() != 0) chk("RD_DATA", 32'(RD_DATA), 32'(mq[0]));
    end
  end

  task automatic cyc(input bit w, input logic [7:0] d, input bit r);
    WR_EN   = w;
    WR_DATA = d;
    RD_EN   = r;
    @(posedge CLK);
    #1;
    WR_EN = 1'b0;
    RD_EN = 1'b0;
  endtask

  initial begin
    RST_N = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    chk("rst_empty", 32'(EMPTY), 32'd1);
    chk("rst_full",  32'(FULL),  32'd0);
    chk("rst_level", 32'(LEVEL), 32'd0);
    chk("rst_ovf",   32'(OVF),   32'd0);
    chk("rst_udf",   32'(UDF),   32'd0);

    cyc(1'b1, 8'hA5, 1'b0);
    chk("single_empty", 32'(EMPTY),   32'd0);
    chk("single_data",  32'(RD_DATA), 32'hA5);
    chk("single_level", 32'(LEVEL),   32'd1);
    cyc(1'b0, 8'h00, 1'b1);
    chk("single_pop_empty", 32'(EMPTY), 32'd1);
    chk("single_pop_level", 32'(LEVEL), 32'd0);

    for (int i = 0; i < CAP; i++) begin
      cyc(1'b1, 8'(i), 1'b0);
      if (i == CAP - 2) chk("fill_not_full", 32'(FULL), 32'd0);
    end
    chk("fill_full",  32'(FULL),  32'd1);
    chk("fill_level", 32'(LEVEL), 32'(CAP));
    cyc(1'b1, 8'hFF, 1'b0);
    chk("ovf_set",   32'(OVF),   32'd1);
    chk("ovf_level", 32'(LEVEL), 32'(CAP));
    for (int i = 0; i < CAP; i++) begin
      chk("drain_data", 32'(RD_DATA), 32'(8'(i)));
      cyc(1'b0, 8'h00, 1'b1);
    end
    chk("drain_empty", 32'(EMPTY), 32'd1);

    cyc(1'b1, 8'h3C, 1'b1);
    chk("udf_set",   32'(UDF),     32'd1);
    chk("udf_level", 32'(LEVEL),   32'd1);
    chk("udf_data",  32'(RD_DATA), 32'h3C);
    cyc(1'b0, 8'h00, 1'b1);

    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0);
    for (int i = 0; i < 300; i++) cyc(1'b1, 8'(i * 7 + 3), 1'b1);
    chk("stream_level", 32'(LEVEL), 32'd5);
    chk("stream_head",  32'(RD_DATA), 32'h14);
    for (int i = 0; i < 5; i++) cyc(1'b0, 8'h00, 1'b1);
    chk("stream_empty", 32'(EMPTY), 32'd1);

    for (int i = 0; i < 40; i++) cyc(1'b1, 8'(8'h80 + i), 1'b0);
    chk("pre_rst_level", 32'(LEVEL), 32'd40);
    RST_N = 1'b0;
    cyc(1'b1, 8'h99, 1'b0);
    RST_N = 1'b1;
    chk("mid_rst_level", 32'(LEVEL), 32'd0);
    chk("mid_rst_empty", 32'(EMPTY), 32'd1);
    chk("mid_rst_ovf",   32'(OVF),   32'd0);
    chk("mid_rst_udf",   32'(UDF),   32'd0);
    cyc(1'b1, 8'h11, 1'b0);
    cyc(1'b1, 8'h22, 1'b0);
    chk("post_rst_head",  32'(RD_DATA), 32'h11);
    chk("post_rst_level", 32'(LEVEL),   32'd2);
    cyc(1'b0, 8'h00, 1'b1);
    chk("post_rst_next",  32'(RD_DATA), 32'h22);
    cyc(1'b0, 8'h00, 1'b1);
    @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
